// File: rtl/serial_arbiter.sv
// rtl/serial_arbiter.sv - two-requester round-robin arbiter and burst sequencer for the 3-wire serial controller
module serial_arbiter #(
    parameter int BITS     = 8,
    parameter int LEN_BITS = 4
) (
    input  logic                serial_clk,
    input  logic                in_rst,
    input  logic [1:0]          in_req,
    input  logic [LEN_BITS-1:0] in_len_0,
    input  logic [LEN_BITS-1:0] in_len_1,
    input  logic [BITS-1:0]     in_wdata_0,
    input  logic [BITS-1:0]     in_wdata_1,
    output logic [1:0]          out_grant,
    output logic [1:0]          out_wack,
    output logic [BITS-1:0]     out_rdata,
    output logic [1:0]          out_rvalid,
    output logic [1:0]          out_done,
    output logic                out_ser_enable,
    output logic [BITS-1:0]     out_ser_parallel,
    input  logic                in_ser_ready,
    input  logic                in_ser_word_finished,
    input  logic [BITS-1:0]     in_ser_parallel
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

    localparam logic [LEN_BITS-1:0] LEN_ONE = 1;

    state_t              state, state_nxt;
    logic                rr, rr_nxt;
    logic                g, g_nxt;
    logic                pick;
    logic [LEN_BITS-1:0] len, len_nxt;
    logic [LEN_BITS-1:0] word_ctr, word_ctr_nxt;
    logic [1:0]          grant_nxt, wack_nxt, rvalid_nxt, done_nxt;
    logic [BITS-1:0]     rdata_nxt;
    logic                enable_nxt;

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            state          <= S_IDLE;
            rr             <= 1'b0;
            g              <= 1'b0;
            len            <= '0;
            word_ctr       <= '0;
            out_grant      <= '0;
            out_wack       <= '0;
            out_rvalid     <= '0;
            out_done       <= '0;
            out_rdata      <= '0;
            out_ser_enable <= 1'b0;
        end else begin
            state          <= state_nxt;
            rr             <= rr_nxt;
            g              <= g_nxt;
            len            <= len_nxt;
            word_ctr       <= word_ctr_nxt;
            out_grant      <= grant_nxt;
            out_wack       <= wack_nxt;
            out_rvalid     <= rvalid_nxt;
            out_done       <= done_nxt;
            out_rdata      <= rdata_nxt;
            out_ser_enable <= enable_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr;
        g_nxt        = g;
        len_nxt      = len;
        word_ctr_nxt = word_ctr;
        grant_nxt    = out_grant;
        wack_nxt     = '0;
        rvalid_nxt   = '0;
        done_nxt     = '0;
        rdata_nxt    = out_rdata;
        enable_nxt   = out_ser_enable;
        // Contention goes to rr; otherwise the single requester wins.
        pick         = (in_req == 2'b11) ? rr : in_req[1];

        case (state)
            S_IDLE: begin
                if (in_req != 2'b00) begin
                    g_nxt        = pick;
                    len_nxt      = pick ? in_len_1 : in_len_0;
                    word_ctr_nxt = '0;
                    grant_nxt    = pick ? 2'b10 : 2'b01;
                    if (len_nxt == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        enable_nxt = 1'b1;
                        state_nxt  = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (in_ser_word_finished) begin
                    rdata_nxt     = in_ser_parallel;
                    rvalid_nxt[g] = 1'b1;
                    // Dropping enable on this edge stops the controller before another word starts.
                    if (word_ctr == len - LEN_ONE) begin
                        enable_nxt = 1'b0;
                        state_nxt  = S_DRAIN;
                    end else begin
                        word_ctr_nxt = word_ctr + LEN_ONE;
                        wack_nxt[g]  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (in_ser_ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_nxt[g] = 1'b1;
                grant_nxt   = '0;
                rr_nxt      = ~g;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_ser_parallel = (state == S_XFER) ? (g ? in_wdata_1 : in_wdata_0) : '1;

endmodule
